// File: rtl/bus_slave_ram_if.sv
// rtl/bus_slave_ram_if.sv - bus slave request/return bundle; oorErr present when BUS_SLAVE_OOR_CHK_EN is defined
interface bus_slave_ram_if;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [29:0] addr;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        rdy_;
`ifdef BUS_SLAVE_OOR_CHK_EN
  logic        oorErr;

  modport master (output cs_, as_, rw, addr, wrData, input rdData, rdy_, oorErr);
  modport slave  (input cs_, as_, rw, addr, wrData, output rdData, rdy_, oorErr);
`else
  modport master (output cs_, as_, rw, addr, wrData, input rdData, rdy_);
  modport slave  (input cs_, as_, rw, addr, wrData, output rdData, rdy_);
`endif
endinterface

// File: rtl/bus_slave_ram.sv
// rtl/bus_slave_ram.sv - wait-state scratchpad RAM bus slave; optional range check via BUS_SLAVE_OOR_CHK_EN
module bus_slave_ram #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  bus_slave_ram_if.slave bus
);

  localparam int         IW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t         state;
  state_t         state_nx;
  logic [3:0]     wait_cnt;
  logic [3:0]     wait_cnt_nx;
  logic           accept;

  logic [29:0]    lat_addr;
  logic           lat_rw;
  logic [31:0]    lat_wdata;

  // While idle the live bus request is the one being looked at; afterwards the latched copy.
  logic [29:0]    sel_addr;
  logic           sel_rw;
  logic [IW-1:0]  sel_idx;
  logic           sel_ok;

  logic [31:0]    mem [DEPTH];
  logic           rdy_q;
  logic [31:0]    rd_q;
  logic           wr_en;

  assign sel_addr = (state == S_IDLE) ? bus.addr : lat_addr;
  assign sel_rw   = (state == S_IDLE) ? bus.rw   : lat_rw;
  assign sel_idx  = sel_addr[IW-1:0];

`ifdef BUS_SLAVE_OOR_CHK_EN
  assign sel_ok = ~|sel_addr[29:IW];
`else
  // Upper address bits alias; they are deliberately not decoded.
  logic unused_hi;
  assign unused_hi = ^sel_addr[29:IW];
  assign sel_ok    = 1'b1;
`endif

  // Next-state and wait counter: accept in IDLE, count down in WAIT, single ACK cycle.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    accept      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.cs_ && !bus.as_) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = S_ACK;
          end else begin
            state_nx    = S_WAIT;
            wait_cnt_nx = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nx = S_ACK;
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, counter and request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      lat_addr  <= 30'd0;
      lat_rw    <= 1'b0;
      lat_wdata <= 32'h0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (accept) begin
        lat_addr  <= bus.addr;
        lat_rw    <= bus.rw;
        lat_wdata <= bus.wrData;
      end
    end
  end

  // Registered return path: ready and read data are loaded on the edge entering ACK so rdData is zero elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q <= 1'b1;
      rd_q  <= 32'h0;
    end else begin
      rdy_q <= (state_nx != S_ACK);
      rd_q  <= (state_nx == S_ACK && sel_rw && sel_ok) ? mem[sel_idx] : 32'h0;
    end
  end

  // A write commits at the end of ACK unless reset is dropping the transaction.
  assign wr_en = (state == S_ACK) && !lat_rw && sel_ok && !reset;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[sel_idx] <= lat_wdata;
    end
  end

  assign bus.rdy_   = rdy_q;
  assign bus.rdData = rd_q;

`ifdef BUS_SLAVE_OOR_CHK_EN
  logic oor_q;

  // Sticky out-of-range flag, raised together with the ACK pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      oor_q <= 1'b0;
    end else if (state_nx == S_ACK && !sel_ok) begin
      oor_q <= 1'b1;
    end
  end

  assign bus.oorErr = oor_q;
`endif

endmodule

// File: tb/tb_bus_slave_ram.sv
// tb/tb_bus_slave_ram.sv - self-checking bench for bus_slave_ram at WAIT_CYCLES 1, 0 and 3
module tb_bus_slave_ram;

  localparam int DEPTH = 1024;
  localparam int NDUT  = 3;

  logic        clk = 1'b0;
  logic        rst    [NDUT];
  logic        cs_n   [NDUT];
  logic        as_n   [NDUT];
  logic        rw_v   [NDUT];
  logic [29:0] addr_v [NDUT];
  logic [31:0] wd_v   [NDUT];
  logic [31:0] rd_v   [NDUT];
  logic        rdy_v  [NDUT];
  logic        oor_v  [NDUT];

  logic [31:0] ref_mem [NDUT][DEPTH];
  bit          ref_oor [NDUT];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_slave_ram_if bus0 ();
  bus_slave_ram_if bus1 ();
  bus_slave_ram_if bus2 ();

  assign bus0.cs_ = cs_n[0]; assign bus0.as_ = as_n[0]; assign bus0.rw = rw_v[0];
  assign bus0.addr = addr_v[0]; assign bus0.wrData = wd_v[0];
  assign bus1.cs_ = cs_n[1]; assign bus1.as_ = as_n[1]; assign bus1.rw = rw_v[1];
  assign bus1.addr = addr_v[1]; assign bus1.wrData = wd_v[1];
  assign bus2.cs_ = cs_n[2]; assign bus2.as_ = as_n[2]; assign bus2.rw = rw_v[2];
  assign bus2.addr = addr_v[2]; assign bus2.wrData = wd_v[2];

  assign rd_v[0] = bus0.rdData; assign rdy_v[0] = bus0.rdy_;
  assign rd_v[1] = bus1.rdData; assign rdy_v[1] = bus1.rdy_;
  assign rd_v[2] = bus2.rdData; assign rdy_v[2] = bus2.rdy_;
`ifdef BUS_SLAVE_OOR_CHK_EN
  assign oor_v[0] = bus0.oorErr; assign oor_v[1] = bus1.oorErr; assign oor_v[2] = bus2.oorErr;
`else
  assign oor_v[0] = 1'b0; assign oor_v[1] = 1'b0; assign oor_v[2] = 1'b0;
`endif

  bus_slave_ram #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .reset(rst[0]), .bus(bus0));
  bus_slave_ram #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .reset(rst[1]), .bus(bus1));
  bus_slave_ram #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .reset(rst[2]), .bus(bus2));

  function automatic int wcyc(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  function automatic bit in_range(input logic [29:0] a);
`ifdef BUS_SLAVE_OOR_CHK_EN
    return int'(a) < DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  function automatic string tag(input string s, input int d);
    return $sformatf("%s[w%0d]", s, wcyc(d));
  endfunction

  task automatic check(input string t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
  endtask

  task automatic check_oor(input int d);
`ifdef BUS_SLAVE_OOR_CHK_EN
    check(tag("oorErr", d), 32'(oor_v[d]), 32'(ref_oor[d]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string s, input int d);
    check(tag({s, "_rdy"}, d), 32'(rdy_v[d]), 32'h1);
    check(tag({s, "_rdData"}, d), rd_v[d], 32'h0);
  endtask

  // One transaction from the IDLE cycle; ack expected exactly WAIT_CYCLES+1 cycles after the accept edge.
  task automatic xact(input int d, input bit r, input logic [29:0] a, input logic [31:0] wd,
                      output logic [31:0] got);
    int          w;
    int          idx;
    bit          ok;
    logic [31:0] exp_rd;
    w      = wcyc(d);
    idx    = int'(a) % DEPTH;
    ok     = in_range(a);
    exp_rd = (r && ok) ? ref_mem[d][idx] : 32'h0;
    got    = 32'h0;
    cs_n[d] = 1'b0; as_n[d] = 1'b0; rw_v[d] = r; addr_v[d] = a; wd_v[d] = wd;
    tick();
    cs_n[d] = 1'b1; as_n[d] = 1'b1;
    rw_v[d] = 1'($urandom); addr_v[d] = 30'($urandom); wd_v[d] = $urandom;
    for (int k = 1; k <= w + 1; k++) begin
      if (k == w + 1) begin
        check(tag("rdy_ack", d), 32'(rdy_v[d]), 32'h0);
        check(tag("rdData_ack", d), rd_v[d], exp_rd);
        got = rd_v[d];
        if (!ok) ref_oor[d] = 1'b1;
      end else begin
        check_quiet("wait", d);
      end
      check_oor(d);
      tick();
    end
    if (!r && ok) ref_mem[d][idx] = wd;
    check_quiet("after", d);
  endtask

  logic [31:0] got;
  logic [29:0] ra;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; cs_n[d] = 1'b1; as_n[d] = 1'b1; rw_v[d] = 1'b1;
      addr_v[d] = 30'd0; wd_v[d] = 32'h0; ref_oor[d] = 1'b0;
    end

    // Reset then idle bus: no ready, no data.
    tick(); tick();
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int d = 0; d < NDUT; d++) begin
        check_quiet("idle", d);
        check_oor(d);
      end
      tick();
    end

    // Known contents in the low 16 words of every instance.
    for (int d = 0; d < NDUT; d++)
      for (int a = 0; a < 16; a++)
        xact(d, 1'b0, 30'(a), $urandom, got);

    // Write then read back, WAIT_CYCLES=1.
    xact(0, 1'b0, 30'd5, 32'hDEADBEEF, got);
    xact(0, 1'b1, 30'd5, 32'h0, got);
    check("wr_rd_addr5", got, 32'hDEADBEEF);

    // Held read request with zero wait: ready every second cycle.
    cs_n[1] = 1'b0; as_n[1] = 1'b0; rw_v[1] = 1'b1; addr_v[1] = 30'd7;
    tick();
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("b2b_rdy_k%0d", k), 32'(rdy_v[1]), (k % 2 == 1) ? 32'h0 : 32'h1);
      check($sformatf("b2b_rdData_k%0d", k), rd_v[1], (k % 2 == 1) ? ref_mem[1][7] : 32'h0);
      if (k == 12) begin
        cs_n[1] = 1'b1; as_n[1] = 1'b1;
      end
      tick();
    end
    check_quiet("b2b_end", 1);

    // Strobe dropped after accept does not abort, WAIT_CYCLES=3.
    xact(2, 1'b0, 30'd9, 32'h12345678, got);
    xact(2, 1'b1, 30'd9, 32'h0, got);
    check("abort_ignored_addr9", got, 32'h12345678);

    // Reset during WAIT drops the write.
    xact(2, 1'b0, 30'd2, 32'h1, got);
    cs_n[2] = 1'b0; as_n[2] = 1'b0; rw_v[2] = 1'b0; addr_v[2] = 30'd2; wd_v[2] = 32'hAAAA5555;
    tick();
    cs_n[2] = 1'b1; as_n[2] = 1'b1;
    check_quiet("rst_wait_t1", 2);
    tick();
    rst[2] = 1'b1;
    check_quiet("rst_wait_t2", 2);
    tick();
    rst[2] = 1'b0;
    ref_oor[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_quiet("rst_wait_post", 2);
      check_oor(2);
      tick();
    end
    xact(2, 1'b1, 30'd2, 32'h0, got);
    check("rst_wait_addr2", got, 32'h1);

    // Reset during the ACK cycle also drops the write.
    xact(0, 1'b0, 30'd3, 32'h0000CAFE, got);
    cs_n[0] = 1'b0; as_n[0] = 1'b0; rw_v[0] = 1'b0; addr_v[0] = 30'd3; wd_v[0] = 32'h5A5A5A5A;
    tick();
    cs_n[0] = 1'b1; as_n[0] = 1'b1;
    check_quiet("rst_ack_wait", 0);
    tick();
    check("rst_ack_rdy", 32'(rdy_v[0]), 32'h0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    ref_oor[0] = 1'b0;
    check_quiet("rst_ack_post", 0);
    tick();
    xact(0, 1'b1, 30'd3, 32'h0, got);
    check("rst_ack_addr3", got, 32'h0000CAFE);

    // Reset together with a request: not accepted.
    rst[1] = 1'b1; cs_n[1] = 1'b0; as_n[1] = 1'b0; rw_v[1] = 1'b1; addr_v[1] = 30'd7;
    tick();
    rst[1] = 1'b0; cs_n[1] = 1'b1; as_n[1] = 1'b1;
    ref_oor[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_quiet("rst_req", 1);
      tick();
    end

    // Address 1024: aliases onto word 0, or is rejected with the range check.
    xact(0, 1'b0, 30'd0, 32'h0BADF00D, got);
    xact(0, 1'b0, 30'd1024, 32'hFFFFFFFF, got);
    xact(0, 1'b1, 30'd0, 32'h0, got);
`ifdef BUS_SLAVE_OOR_CHK_EN
    check("oor_addr0_kept", got, 32'h0BADF00D);
    xact(0, 1'b1, 30'd1024, 32'h0, got);
    check("oor_read_zero", got, 32'h0);
    check("oor_sticky", 32'(oor_v[0]), 32'h1);
`else
    check("alias_addr0", got, 32'hFFFFFFFF);
`endif

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 60; i++) begin
      int d;
      d  = $urandom_range(0, NDUT - 1);
      ra = 30'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra = ra + 30'($urandom_range(1, 1048575)) * 30'(DEPTH);
      xact(d, 1'($urandom), ra, $urandom, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_slave_ram.md
Name: bus_slave_ram

Overview:
- Word-addressed scratchpad RAM that acts as a bus slave (the responder end of the slave-return path).
- Accepts chip-selected read/write requests from the bus master, inserts a fixed number of wait states, then returns one active-low ready pulse plus read data.
- Its rdData/rdy_ outputs connect directly to one sN slot (sNRdData/sNRdy_) of the slave-side return mux. Its cs_ comes from the address decoder.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, 2..65536.
- WAIT_CYCLES, 1, wait states between request acceptance and ready; 0..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- cs_  input  1  chip select, active low; 0 = this slave is selected.
- as_  input  1  address strobe, active low; 0 = request valid.
- rw  input  1  1 = read, 0 = write.
- addr  input  30  word address.
- wrData  input  32  write data.
- rdData  output  32  read data; nonzero only during the ready cycle of a read.
- rdy_  output  1  ready, active low; low for exactly one cycle per transaction.
- oorErr  output  1  sticky out-of-range flag; exists only when BUS_SLAVE_OOR_CHK_EN is defined.

Behaviour:
- Single clock domain. Reset is synchronous and active-high (clk, reset).
- Reset values: rdy_=1, rdData=32'h0, state=IDLE, wait counter=0, oorErr=0. RAM contents are not cleared.
- FSM has three states: IDLE, WAIT, ACK.
- IDLE:
  - Acceptance condition: cs_==0 and as_==0, sampled on a clock edge.
  - On acceptance, latch addr, rw and wrData.
  - Next state is WAIT with counter=WAIT_CYCLES-1, or ACK directly if WAIT_CYCLES==0.
- WAIT:
  - Counter decrements each cycle.
  - Move to ACK on the cycle after the counter reads 0.
  - Bus inputs are ignored; deasserting as_ or cs_ does not abort the transaction.
- ACK:
  - rdy_=0 for exactly one cycle.
  - Read: rdData = mem[latched index].
  - Write: mem[latched index] <= latched wrData, committed at the end of the ACK cycle.
  - Next state is always IDLE. A request present during ACK is not accepted.
- Latency: request sampled at edge T gives rdy_ low in cycle T+1+WAIT_CYCLES.
- Throughput: one transaction per WAIT_CYCLES+2 cycles. A held request is re-accepted in the IDLE cycle after ACK.
- Outputs are registered: rdy_ and rdData are driven from flops, with no combinational path from the inputs.
- rdData is 32'h0 in every cycle except the ACK of a read. This keeps OR-style return paths safe.
- Index = latched addr[log2(DEPTH)-1:0].
- Read-after-write to the same address in back-to-back transactions returns the new data (the write commits before the next accept).
- Reset asserted in any state: next cycle is IDLE with rdy_=1. An in-flight write is dropped (RAM unchanged).
- Simultaneous reset and request: reset wins and the request is not accepted.

Optional Feature:
- Macro: BUS_SLAVE_OOR_CHK_EN.
- Defined:
  - A latched addr >= DEPTH (any upper bit set) is out-of-range.
  - Out-of-range read: ACK returns rdData=32'h0.
  - Out-of-range write: discarded.
  - The ACK pulse still occurs with normal timing.
  - oorErr goes to 1 in the ACK cycle and stays 1 until reset.
- Not defined:
  - Upper address bits are ignored; addresses alias modulo DEPTH.
  - The oorErr port is absent.

Test Plan:
- Reset, idle: assert reset 2 cycles, release, hold cs_=as_=1 for 10 cycles -> rdy_ stays 1 and rdData stays 0 throughout.
- Write then read, WAIT_CYCLES=1:
  - Write addr=5, wrData=32'hDEADBEEF accepted at T -> rdy_ low only at T+2.
  - Read addr=5 accepted at T+3 -> rdy_ low at T+5 with rdData=32'hDEADBEEF; rdData=0 in all other cycles.
- Zero wait, back-to-back, WAIT_CYCLES=0: hold cs_=as_=0, rw=1, addr=7 continuously -> rdy_ pulses low every 2nd cycle, never 2 consecutive cycles.
- Abort ignored, WAIT_CYCLES=3: write addr=9 with data 32'h12345678, deassert as_ one cycle after acceptance -> rdy_ still low at T+4; a later read of addr 9 returns 32'h12345678.
- Reset mid-wait, WAIT_CYCLES=3:
  - Write addr=2 with data 32'hAAAA5555 over prior content 32'h1.
  - Assert reset at T+2 -> no rdy_ pulse, and a subsequent read of addr 2 returns 32'h1.
- Out-of-range, DEPTH=1024:
  - With BUS_SLAVE_OOR_CHK_EN: write addr=1024 with data 32'hFFFFFFFF -> ack on time, oorErr=1 sticky; a read of addr 0 returns its prior value and a read of addr 1024 returns 0.
  - Without the macro: a read of addr 0 returns 32'hFFFFFFFF (aliasing).
